alu_mul_seq: RTL

Multi-cycle unsigned multiplier sequencer that borrows the shared 16-bit ALU to compute a full-width product by shift-and-add. Sits beside the CPU datapath. While a multiply is in progress it asserts `alu_own`, which steers the ALU operand and opcode muxes to this block. It drives ADD operations only; all shifting is done in its own registers. Results are a 32-bit product plus a one-cycle `done` pulse.

---
 rtl/alu_mul_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
//   Multi-cycle unsigned shift-and-add multiplier. It borrows the shared ALU
//   for its ADD steps and does all shifting in local registers. The result is
//   a 2*WIDTH-bit product, announced by a one-cycle done pulse.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start            request, sampled only in IDLE
//   mcand, mplr      operands, captured when start is accepted
//   busy             high while in the ADD/SHIFT states
//   done             one-cycle pulse in the DONE state; product valid
//   product          result, held until the next operation completes
//   alu_own          ALU mux select to this block (mirrors busy)
//   alu_in1/alu_in2  ALU operands (zero outside ADD)
//   alu_opcode       ALU opcode, always 0 (add)
//   alu_result/alu_c combinational ALU sum and carry-out
//
// Build option
//   ALU_MUL_SKIP_ZERO_EN  skip the ADD step for zero multiplier bits, so
//                         latency becomes WIDTH+1+popcount(mplr)
// -----------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplr,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 alu_own,
    output logic [WIDTH-1:0]     alu_in1,
    output logic [WIDTH-1:0]     alu_in2,
    output logic [3:0]           alu_opcode,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_c
);

    localparam int          CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0]  OP_ADD = 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     acc_q, lo_q, mq_q, mc_q;
    logic                 cy_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q, done_q;
    logic [2*WIDTH-1:0]   product_q;

    // {cy,acc,lo} >> 1: the add carry becomes the new top bit, so no
    // product bit is lost even when acc + mc overflows WIDTH bits.
    logic [2*WIDTH-1:0]   shift_d;
    logic                 last_d;
    logic                 start_add_d;  // first step after accept is an ADD
    logic                 next_add_d;   // step after a non-final SHIFT is an ADD

    assign shift_d = {cy_q, acc_q, lo_q[WIDTH-1:1]};
    assign last_d  = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef ALU_MUL_SKIP_ZERO_EN
    // Only spend an ADD cycle when the bit about to be consumed is set.
    // After a SHIFT, mq has not yet moved, so the next bit is mq[1].
    assign start_add_d = mplr[0];
    assign next_add_d  = mq_q[1];
`else
    assign start_add_d = 1'b1;
    assign next_add_d  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            lo_q      <= '0;
            mq_q      <= '0;
            mc_q      <= '0;
            cy_q      <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mc_q    <= mcand;
                        mq_q    <= mplr;
                        acc_q   <= '0;
                        lo_q    <= '0;
                        cy_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= start_add_d ? S_ADD : S_SHIFT;
                    end
                end
                S_ADD: begin
                    acc_q   <= alu_result;
                    cy_q    <= alu_c;
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    {acc_q, lo_q} <= shift_d;
                    mq_q          <= mq_q >> 1;
                    cy_q          <= 1'b0;
                    cnt_q         <= cnt_q + 1'b1;
                    if (last_d) begin
                        // product/done registered here so they are visible
                        // throughout the DONE cycle
                        product_q <= shift_d;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_DONE;
                    end else begin
                        state_q <= next_add_d ? S_ADD : S_SHIFT;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ALU operands are decoded from registered state only, so they settle
    // early in the ADD cycle and are forced to zero everywhere else.
    always_comb begin
        alu_in1    = '0;
        alu_in2    = '0;
        alu_opcode = OP_ADD;
        if (state_q == S_ADD) begin
            alu_in1 = acc_q;
            alu_in2 = mq_q[0] ? mc_q : '0;
        end
    end

    assign busy    = busy_q;
    assign alu_own = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
